dm_pipe: RTL and testbench

Parametrised data memory for the pipelined CPU's MEM stage. It succeeds the single-cycle word/byte/half memory with four additions:
- a valid/ready request port;
- configurable load latency with one access in flight;
- a misaligned/out-of-range error response;
- a sequential clear sweep replacing the one-cycle array wipe.

Size encoding and sign/zero extension rules are unchanged.

---
 rtl/dm_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_dm_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_pipe.sv
// Pipelined MEM-stage data memory: valid/ready request port, RD_LAT load latency,
// error response and a sequential clear sweep. Define DM_PIPE_TRACE_EN to print store traces.
module dm_pipe #(
  parameter int unsigned DEPTH_WORDS = 8192,
  parameter int unsigned RD_LAT      = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam int unsigned LAT_W    = 2;
  localparam int unsigned LAT_LAST = (RD_LAT > 1) ? RD_LAT - 2 : 0;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD, S_RESP} state_e;

  state_e             state_q;
  logic [AW-1:0]      clr_cnt_q;
  logic [LAT_W-1:0]   lat_q;
  logic [AW-1:0]      ld_idx_q;
  logic [1:0]         ld_size_q;
  logic [1:0]         ld_off_q;
  logic               req_ready_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_rdata_q;
  logic               rsp_err_q;
  logic               busy_q;

  logic [31:0]        mem_q [DEPTH_WORDS];

  logic [AW-1:0]      req_idx;
  logic               req_err;
  logic               accept;
  logic               store_we;
  logic [31:0]        store_word;
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [31:0]        mem_wdata;

  // Extract and extend the addressed byte/half/word of a stored word.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] size,
                                           input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    unique case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    unique case (size)
      2'b00:   load_ext = w;
      2'b01:   load_ext = {{24{b[7]}}, b};
      2'b10:   load_ext = {24'h0, b};
      default: load_ext = {{16{h[15]}}, h};
    endcase
  endfunction

  // Merge low-aligned store data into the old word at the selected lanes.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] off);
    store_merge = old;
    unique case (size)
      2'b00: store_merge = wd;
      2'b11: begin
        if (off[1]) store_merge[31:16] = wd[15:0];
        else        store_merge[15:0]  = wd[15:0];
      end
      default: begin
        unique case (off)
          2'd0:    store_merge[7:0]   = wd[7:0];
          2'd1:    store_merge[15:8]  = wd[7:0];
          2'd2:    store_merge[23:16] = wd[7:0];
          default: store_merge[31:24] = wd[7:0];
        endcase
      end
    endcase
  endfunction

  assign req_idx    = req_addr[AW+1:2];
  assign req_err    = ((req_size == 2'b00) && (req_addr[1:0] != 2'b00)) ||
                      ((req_size == 2'b11) && req_addr[0]) ||
                      ((req_addr >> (AW + 2)) != 32'd0);
  assign accept     = (state_q == S_IDLE) && req_valid && !clr;
  assign store_we   = accept && req_we && !req_err;
  assign store_word = store_merge(mem_q[req_idx], req_wdata, req_size, req_addr[1:0]);

  // Single write port shared by the clear sweep and stores.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = req_idx;
    mem_wdata = store_word;
    if (!clr && (state_q == S_CLEAR)) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end else if (store_we) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Control FSM with registered outputs; clr wins over everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_CLEAR;
      clr_cnt_q   <= '0;
      lat_q       <= '0;
      ld_idx_q    <= '0;
      ld_size_q   <= 2'b00;
      ld_off_q    <= 2'b00;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      unique case (state_q)
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + AW'(1);
          if (clr_cnt_q == AW'(DEPTH_WORDS - 1)) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        S_IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (req_err || req_we) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= req_err;
            end else if (RD_LAT == 1) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= load_ext(mem_q[req_idx], req_size, req_addr[1:0]);
            end else begin
              state_q   <= S_LOAD;
              lat_q     <= '0;
              ld_idx_q  <= req_idx;
              ld_size_q <= req_size;
              ld_off_q  <= req_addr[1:0];
            end
          end
        end
        S_LOAD: begin
          if (lat_q == LAT_W'(LAT_LAST)) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_ext(mem_q[ld_idx_q], ld_size_q, ld_off_q);
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

`ifdef DM_PIPE_TRACE_EN
  always_ff @(posedge clk) begin
    if (store_we) $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, store_word);
  end
`else
  logic unused_pc;
  assign unused_pc = ^req_pc;
`endif

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dm_pipe.sv
// Scoreboard bench for dm_pipe: byte-array reference model, directed plan items and random traffic.
module tb_dm_pipe;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned LAT   = 3;
  localparam int unsigned BYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  dm_pipe #(.DEPTH_WORDS(DEPTH), .RD_LAT(LAT)) dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mb [BYTES];
  int         edge_n = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: memory as a flat byte array.
  task automatic model_clear();
    for (int i = 0; i < BYTES; i++) mb[i] = 8'h00;
  endtask

  task automatic model_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, output exp_t e);
    int   n;
    logic [31:0] v;
    e.err   = (addr >= BYTES) || (size == 2'b00 && addr % 4 != 0) || (size == 2'b11 && addr % 2 != 0);
    e.rdata = '0;
    n = (size == 2'b00) ? 4 : (size == 2'b11) ? 2 : 1;
    if (!e.err) begin
      if (we) begin
        for (int k = 0; k < n; k++) mb[addr + k] = 8'(wdata >> (8 * k));
      end else begin
        v = '0;
        for (int k = 0; k < n; k++) v = v | (32'(mb[addr + k]) << (8 * k));
        if (size == 2'b01 && v[7])  v = v | 32'hFFFF_FF00;
        if (size == 2'b11 && v[15]) v = v | 32'hFFFF_0000;
        e.rdata = v;
      end
    end
  endtask

  // Monitor: cycle k is the period ending at edge k, so sampling after edge E is cycle E+1.
  always @(posedge clk) begin
    exp_t e;
    edge_n++;
    #1;
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_cycle", 32'(edge_n + 1), 32'(e.cyc));
      end
    end
  end

  // All driver tasks start and end 2 time units after a rising edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pc);
    exp_t e;
    int   t_acc;
    int   waited = 0;
    while (req_ready !== 1'b1 && waited < 40) begin
      @(posedge clk); #2;
      waited++;
    end
    if (req_ready !== 1'b1) begin
      chk("ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata; req_pc = pc;
    t_acc = edge_n + 1;
    model_access(we, size, addr, wdata, e);
    e.cyc = (we || e.err) ? t_acc + 1 : t_acc + int'(LAT);
    sb_q.push_back(e);
    @(posedge clk); #2;
    req_valid = 1'b0;
    waited = 0;
    while (1) begin
      chk("ready_low_in_flight", 32'(req_ready), 32'd0);
      if (sb_q.size() == 0) break;
      if (waited >= 20) begin
        chk("rsp_timeout", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        break;
      end
      @(posedge clk); #2;
      waited++;
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk); #2;
    clr = 1'b0;
    model_clear();
  endtask

  // Called just after a clr edge: reset values, then DEPTH cycles of sweep.
  task automatic sweep_check();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    for (int i = 0; i < int'(DEPTH); i++) begin
      chk("sweep_ready_low", 32'(req_ready), 32'd0);
      @(posedge clk); #2;
    end
    chk("sweep_done_ready", 32'(req_ready), 32'd1);
    chk("sweep_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we;
    logic [1:0]  sz;
    logic [31:0] a;
    int unsigned r;

    @(posedge clk); #2;
    pulse_clr();
    sweep_check();
    issue(1'b0, 2'b00, 32'h0, 32'h0, 32'h100);

    // Byte merge into a word, then signed/unsigned byte loads
    issue(1'b1, 2'b00, 32'h4, 32'h1122_3344, 32'h104);
    issue(1'b1, 2'b01, 32'h6, 32'h0000_00AB, 32'h108);
    issue(1'b0, 2'b00, 32'h4, 32'h0, 32'h10C);
    issue(1'b0, 2'b01, 32'h6, 32'h0, 32'h110);
    issue(1'b0, 2'b10, 32'h6, 32'h0, 32'h114);

    // Half store and latency
    issue(1'b1, 2'b11, 32'hA, 32'h0000_8000, 32'h118);
    issue(1'b0, 2'b11, 32'hA, 32'h0, 32'h11C);

    // Error responses leave memory untouched
    issue(1'b0, 2'b00, 32'h2, 32'h0, 32'h120);
    issue(1'b1, 2'b11, 32'h5, 32'hFFFF_FFFF, 32'h124);
    issue(1'b0, 2'b00, BYTES, 32'h0, 32'h128);
    issue(1'b1, 2'b00, 32'h6, 32'hDEAD_BEEF, 32'h12C);
    issue(1'b1, 2'b00, BYTES + 4, 32'hDEAD_BEEF, 32'h130);
    issue(1'b0, 2'b00, 32'h4, 32'h0, 32'h134);
    issue(1'b0, 2'b00, 32'h8, 32'h0, 32'h138);

    // Byte store into a zero word (trace line case)
    issue(1'b1, 2'b01, 32'h1, 32'h0000_00CD, 32'h3000);
    issue(1'b0, 2'b00, 32'h0, 32'h0, 32'h3004);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      if (r == 0) a = BYTES + $urandom_range(0, 255);
      else        a = $urandom_range(0, BYTES - 1);
      if (r < 8 && sz == 2'b00) a = a & ~32'h3;
      if (r < 8 && sz == 2'b11) a = a & ~32'h1;
      issue(we, sz, a, $urandom, 32'h4000 + 32'(i * 4));
    end

    // clr one cycle after a load is accepted: response dropped, sweep runs, store cleared
    issue(1'b1, 2'b00, 32'h20, 32'h1234_5678, 32'h5000);
    while (req_ready !== 1'b1) begin @(posedge clk); #2; end
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_addr = 32'h20; req_pc = 32'h5004;
    @(posedge clk); #2;
    req_valid = 1'b0;
    pulse_clr();
    sweep_check();
    issue(1'b0, 2'b00, 32'h20, 32'h0, 32'h5008);

    // clr during CLEAR restarts the sweep
    pulse_clr();
    repeat (5) begin @(posedge clk); #2; end
    pulse_clr();
    sweep_check();

    // clr wins over a simultaneous request in IDLE
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h24; req_wdata = 32'hCAFE_F00D;
    pulse_clr();
    req_valid = 1'b0;
    sweep_check();
    issue(1'b0, 2'b00, 32'h24, 32'h0, 32'h500C);

    repeat (4) begin @(posedge clk); #2; end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
